// File: rtl/light_show_sequencer.sv
// Phase sequencer for the LED light show: walks NUM_PHASES timing phases, each with
// its own tick period and step count, and emits a one-cycle step pulse per step.
module light_show_sequencer #(
  parameter int NUM_PHASES = 3,
  parameter int PH_W       = 2,
  parameter int TICK_W     = 6,
  parameter int REP_W      = 4,
  parameter bit LOOP       = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic                         start_btn,
  input  logic                         pause_btn,
  input  logic [NUM_PHASES*TICK_W-1:0] period_cfg,
  input  logic [NUM_PHASES*REP_W-1:0]  rep_cfg,
  output logic [PH_W-1:0]              phase,
  output logic                         step,
  output logic [REP_W-1:0]             rep_count,
  output logic                         running,
  output logic                         done,
  output logic                         reset_pressed
);

  if (NUM_PHASES < 2 || NUM_PHASES > 16 || (1 << PH_W) < NUM_PHASES) begin : g_bad_cfg
    $error("light_show_sequencer: NUM_PHASES/PH_W combination is not supported");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [REP_W-1:0]    rep_q, rep_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                step_q, step_d;
  logic                running_q, running_d;
  logic                done_q, done_d;
  logic                reset_pressed_q, reset_pressed_d;

  // Button chains: [0],[1] synchronise, [2] is the delayed copy for edge detection.
  logic [2:0]          start_sync_q, start_sync_d;
  logic [2:0]          pause_sync_q, pause_sync_d;
  logic [1:0]          settle_q, settle_d;
  logic                settled;
  logic                start_ev;
  logic                pause_ev;

  logic [TICK_W-1:0]   cur_period;
  logic [REP_W-1:0]    cur_reps;
  logic [TICK_W-1:0]   last_cnt;
  logic [REP_W-1:0]    rep_inc;
  logic                is_last;

  // Edges are only trusted once the whole chain holds sampled values rather than
  // reset values, so a button held through reset release stays silent.
  assign settled  = (settle_q == 2'd3);
  assign start_ev = settled & start_sync_q[2] & ~start_sync_q[1];
  assign pause_ev = settled & pause_sync_q[2] & ~pause_sync_q[1];

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    start_sync_d = {start_sync_q[1:0], start_btn};
    pause_sync_d = {pause_sync_q[1:0], pause_btn};
    settle_d     = settled ? settle_q : settle_q + 2'd1;
  end

  always_comb begin
    cur_period = '0;
    cur_reps   = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (phase_q == PH_W'(p)) begin
        cur_period = period_cfg[p*TICK_W +: TICK_W];
        cur_reps   = rep_cfg[p*REP_W +: REP_W];
      end
    end
  end

  // A period of 0 behaves as 1; comparing with >= lets a shrunken period wrap on the next tick.
  assign last_cnt = (cur_period == '0) ? '0 : cur_period - TICK_W'(1);
  assign rep_inc  = rep_q + REP_W'(1);
  assign is_last  = (phase_q == PH_W'(NUM_PHASES - 1));

  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    rep_d           = rep_q;
    tick_cnt_d      = tick_cnt_q;
    step_d          = 1'b0;
    reset_pressed_d = reset_pressed_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ev) begin
          state_d         = S_RUN;
          phase_d         = '0;
          rep_d           = '0;
          tick_cnt_d      = '0;
          reset_pressed_d = 1'b0;
        end
      end

      S_RUN: begin
        // Pause has priority over start and swallows a coincident tick.
        if (pause_ev) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          if (tick_cnt_q >= last_cnt) begin
            tick_cnt_d = '0;
            step_d     = 1'b1;
            rep_d      = rep_inc;
            // A step count of 0 marks an endless phase; rep_count just wraps.
            if (cur_reps != '0 && rep_inc == cur_reps) begin
              if (!is_last) begin
                phase_d = phase_q + PH_W'(1);
                rep_d   = '0;
              end else if (LOOP) begin
                phase_d = '0;
                rep_d   = '0;
              end else begin
                state_d = S_DONE;
              end
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      S_PAUSE: begin
        if (pause_ev) state_d = S_RUN;
      end

      default: state_d = S_IDLE;
    endcase

    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      phase_q         <= '0;
      rep_q           <= '0;
      tick_cnt_q      <= '0;
      step_q          <= 1'b0;
      running_q       <= 1'b0;
      done_q          <= 1'b0;
      reset_pressed_q <= 1'b1;
      start_sync_q    <= '1;
      pause_sync_q    <= '1;
      settle_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      state_q         <= state_d;
      phase_q         <= phase_d;
      rep_q           <= rep_d;
      tick_cnt_q      <= tick_cnt_d;
      step_q          <= step_d;
      running_q       <= running_d;
      done_q          <= done_d;
      reset_pressed_q <= reset_pressed_d;
      start_sync_q    <= start_sync_d;
      pause_sync_q    <= pause_sync_d;
      settle_q        <= settle_d;
    end
  end

  assign phase         = phase_q;
  assign step          = step_q;
  assign rep_count     = rep_q;
  assign running       = running_q;
  assign done          = done_q;
  assign reset_pressed = reset_pressed_q;

endmodule

// File: tb/tb_light_show_sequencer.sv
// Directed bench for light_show_sequencer: a stop-at-end instance and a looping
// instance share all stimulus; expected values are hand-computed per tick.
module tb_light_show_sequencer;

  localparam int NP     = 3;
  localparam int PH_W   = 2;
  localparam int TICK_W = 6;
  localparam int REP_W  = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     tick;
  logic                     start_btn;
  logic                     pause_btn;
  logic [NP*TICK_W-1:0]     period_cfg;
  logic [NP*REP_W-1:0]      rep_cfg;

  logic [PH_W-1:0]          phase, l_phase;
  logic                     step, l_step;
  logic [REP_W-1:0]         rep_count, l_rep_count;
  logic                     running, l_running;
  logic                     done, l_done;
  logic                     reset_pressed, l_reset_pressed;

  int errors = 0;
  int checks = 0;
  int step_seen = 0;
  int lstep_seen = 0;

  light_show_sequencer #(
    .NUM_PHASES(NP), .PH_W(PH_W), .TICK_W(TICK_W), .REP_W(REP_W), .LOOP(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start_btn(start_btn), .pause_btn(pause_btn),
    .period_cfg(period_cfg), .rep_cfg(rep_cfg), .phase(phase), .step(step),
    .rep_count(rep_count), .running(running), .done(done), .reset_pressed(reset_pressed)
  );

  light_show_sequencer #(
    .NUM_PHASES(NP), .PH_W(PH_W), .TICK_W(TICK_W), .REP_W(REP_W), .LOOP(1'b1)
  ) dut_loop (
    .clk(clk), .reset(reset), .tick(tick), .start_btn(start_btn), .pause_btn(pause_btn),
    .period_cfg(period_cfg), .rep_cfg(rep_cfg), .phase(l_phase), .step(l_step),
    .rep_count(l_rep_count), .running(l_running), .done(l_done),
    .reset_pressed(l_reset_pressed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step)   step_seen++;
    if (l_step) lstep_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One tick pulse followed by idle cycles (tick period of 4 clk); ends 1ns after an edge.
  task automatic do_tick();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit do_start, input bit do_pause);
    @(posedge clk); #1;
    if (do_start) start_btn = 1'b0;
    if (do_pause) pause_btn = 1'b0;
    repeat (6) @(posedge clk);
    #1 start_btn = 1'b1; pause_btn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #2 reset = 1'b0;
    #3 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    int b, lb;
    int exp_d[12] = '{0, 1, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0};
    int exp_l[12] = '{0, 1, 0, 1, 1, 1, 1, 0, 0, 1, 0, 1};

    reset = 1'b0; tick = 1'b0; start_btn = 1'b1; pause_btn = 1'b1;
    period_cfg = {6'd3, 6'd1, 6'd2};
    rep_cfg    = {4'd1, 4'd3, 4'd2};
    repeat (2) @(posedge clk);
    #1;
    check("rst_phase", phase, 0);
    check("rst_rep", rep_count, 0);
    check("rst_step", step, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_flag", reset_pressed, 1);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Basic sequence, periods {2,1,3}, reps {2,3,1}
    press(1, 0);
    check("start_running", running, 1);
    check("start_flag", reset_pressed, 0);
    for (int i = 0; i < 12; i++) begin
      b = step_seen; lb = lstep_seen;
      do_tick();
      check($sformatf("seq_step_t%0d", i + 1), step_seen - b, exp_d[i]);
      check($sformatf("loop_step_t%0d", i + 1), lstep_seen - lb, exp_l[i]);
      if (i == 9) begin
        check("seq_done", done, 1);
        check("seq_done_phase", phase, 2);
        check("seq_done_rep", rep_count, 1);
        check("seq_done_running", running, 0);
        check("loop_wrap_phase", l_phase, 0);
        check("loop_wrap_rep", l_rep_count, 0);
        check("loop_wrap_done", l_done, 0);
        check("loop_wrap_running", l_running, 1);
      end
    end
    check("loop_t12_rep", l_rep_count, 1);
    check("loop_t12_done", l_done, 0);

    // DONE ignores pause, restarts on start
    press(0, 1);
    check("done_pause_ignored", done, 1);
    press(1, 0);
    check("restart_running", running, 1);
    check("restart_done", done, 0);
    check("restart_phase", phase, 0);
    check("restart_rep", rep_count, 0);

    // Reset mid-run in phase 1
    repeat (5) do_tick();
    check("pre_rst_phase", phase, 1);
    check("pre_rst_rep", rep_count, 1);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check("midrst_phase", phase, 0);
    check("midrst_rep", rep_count, 0);
    check("midrst_running", running, 0);
    check("midrst_done", done, 0);
    check("midrst_flag", reset_pressed, 1);
    start_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("held_btn_no_event", running, 0);
    start_btn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    press(1, 0);
    check("post_rst_running", running, 1);
    check("post_rst_flag", reset_pressed, 0);
    check("post_rst_phase", phase, 0);

    // Pause at tick counter 1 of a period-3 phase
    period_cfg = {6'd3, 6'd1, 6'd3};
    rep_cfg    = {4'd1, 4'd3, 4'd0};
    b = step_seen;
    do_tick();
    check("pause_pre_step", step_seen - b, 0);
    press(0, 1);
    check("paused_running", running, 0);
    b = step_seen;
    repeat (5) do_tick();
    check("paused_steps", step_seen - b, 0);
    check("paused_rep", rep_count, 0);
    press(1, 0);
    check("pause_start_ignored", running, 0);
    press(0, 1);
    check("resume_running", running, 1);
    b = step_seen;
    do_tick();
    check("resume_tick1", step_seen - b, 0);
    do_tick();
    check("resume_tick2", step_seen - b, 1);
    check("resume_rep", rep_count, 1);

    // Infinite phase, period 1
    reset_pulse();
    period_cfg = {6'd3, 6'd1, 6'd1};
    rep_cfg    = {4'd1, 4'd3, 4'd0};
    press(1, 0);
    b = step_seen;
    repeat (20) do_tick();
    check("inf_steps", step_seen - b, 20);
    check("inf_phase", phase, 0);
    check("inf_rep", rep_count, 4);
    check("inf_running", running, 1);

    // Period 0 acts as 1; simultaneous start+pause in IDLE starts, in RUN pauses
    reset_pulse();
    period_cfg = {6'd3, 6'd1, 6'd0};
    rep_cfg    = {4'd1, 4'd3, 4'd3};
    press(1, 1);
    check("both_idle_running", running, 1);
    check("both_idle_flag", reset_pressed, 0);
    b = step_seen;
    repeat (3) do_tick();
    check("p0_steps", step_seen - b, 3);
    check("p0_phase", phase, 1);
    check("p0_rep", rep_count, 0);
    press(1, 1);
    check("both_run_paused", running, 0);
    b = step_seen;
    do_tick();
    check("both_run_no_step", step_seen - b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
